// File: rtl/beta_mem_arbiter_if.sv
// Handshake bundle between the Beta fetch/MEM stages, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface beta_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_kill;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/beta_mem_arbiter.sv
// Single-ported memory arbiter for the Beta: data has priority, but fetch is guaranteed a
// grant after MAX_D_STREAK consecutive data grants. One registered transaction at a time.
module beta_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    beta_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    localparam int                SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

    state_t            state_q;
    logic [SW-1:0]     streak_q;
    logic              killed_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic fetch_elig;
    logic grant_data;
    logic grant_fetch;
    logic kill_now;

    always_comb begin
        fetch_elig  = bus.i_req & ~bus.i_kill;
        grant_data  = bus.d_req & (~fetch_elig | (streak_q < STREAK_MAX));
        grant_fetch = fetch_elig & ~grant_data;
        // A kill arriving on the completion edge still suppresses the fetch ack.
        kill_now    = killed_q | bus.i_kill;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            killed_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    killed_q <= 1'b0;
                    if (grant_data) begin
                        state_q     <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr & WORD_MASK;
                        mem_wdata_q <= bus.d_wdata;
                    end else if (grant_fetch) begin
                        state_q     <= BUSY_I;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.i_addr & WORD_MASK;
                        mem_wdata_q <= '0;
                    end
                    // Streak only grows while data overtakes an eligible fetch.
                    if (grant_data && fetch_elig) begin
                        streak_q <= (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
                    end else begin
                        streak_q <= '0;
                    end
                end
                BUSY_I: begin
                    if (bus.i_kill) killed_q <= 1'b1;
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                        if (!kill_now) begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                        d_ack_q   <= 1'b1;
                        d_rdata_q <= bus.mem_rdata;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
